// File: rtl/uart_tx_485_if.sv
// Byte-stream handshake between the NAND read-control stage and the UART/RS-485 transmitter.
// master = upstream byte source, slave = transmitter.
interface uart_tx_485_if;
    logic [7:0] data;
    logic       data_fin;
    logic       tx;
    logic       de;
    logic       transfer_fin;
    logic       busy;
    logic       overrun;

    modport master (
        output data, data_fin,
        input  tx, de, transfer_fin, busy, overrun
    );

    modport slave (
        input  data, data_fin,
        output tx, de, transfer_fin, busy, overrun
    );
endinterface

// File: rtl/uart_tx_485.sv
// Byte-serial UART transmitter with RS-485 driver-enable control, a one-entry holding
// buffer for back-to-back bytes, and a fixed-width byte-sent pulse.
module uart_tx_485 #(
    parameter int unsigned CLK_DIV   = 833,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned FIN_W     = 4,
    parameter int unsigned DE_TAIL   = 8
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_485_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_TAIL
    } state_t;

    localparam logic [15:0] BIT_RELOAD  = 16'(CLK_DIV - 1);
    localparam logic [15:0] TAIL_RELOAD = 16'(DE_TAIL - 1);
    localparam logic [2:0]  STOP_LAST   = 3'(STOP_BITS - 1);
    localparam logic [3:0]  FIN_LOAD    = 4'(FIN_W);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_fin_d;
    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift;
    logic [7:0]  r_buf;
    logic        r_buf_full;
    logic        r_overrun;
    logic [3:0]  r_fin_cnt;

    logic        w_req;
    logic        w_bit_end;
    logic        w_stop_end;
    logic        w_unload;
    logic        w_direct;
    logic        w_to_buf;
    logic        w_drop;
    logic        w_cnt_ld;
    logic [15:0] w_cnt_val;
    logic        w_idx_clr;
    logic        w_idx_inc;
    logic        w_tx;
    logic        w_de;

    assign w_req      = bus.data_fin & ~r_fin_d;
    assign w_bit_end  = (r_cnt == 16'd0);
    assign w_stop_end = (r_state == S_STOP) && w_bit_end && (r_idx == STOP_LAST);
    assign w_unload   = w_stop_end && r_buf_full;

    // A byte arriving in the last stop cycle with nothing queued is sent straight away.
    assign w_direct = w_req && ((r_state == S_IDLE) || (r_state == S_TAIL) ||
                                (w_stop_end && !r_buf_full));
    assign w_to_buf = w_req && !w_direct && (!r_buf_full || w_unload);
    assign w_drop   = w_req && !w_direct && r_buf_full && !w_unload;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_ld    = 1'b0;
        w_cnt_val   = BIT_RELOAD;
        w_idx_clr   = 1'b0;
        w_idx_inc   = 1'b0;
        w_tx        = 1'b1;
        w_de        = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                w_de = 1'b0;
                if (w_req) begin
                    w_state_nxt = S_START;
                    w_cnt_ld    = 1'b1;
                end
            end
            S_START: begin
                w_tx = 1'b0;
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_cnt_ld    = 1'b1;
                    w_idx_clr   = 1'b1;
                end
            end
            S_DATA: begin
                w_tx = r_shift[r_idx];
                if (w_bit_end) begin
                    w_cnt_ld = 1'b1;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
                        w_idx_clr   = 1'b1;
                    end else begin
                        w_idx_inc = 1'b1;
                    end
                end
            end
            S_PAR: begin
                w_tx = (PARITY == 1) ? ~^r_shift : ^r_shift;
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                    w_cnt_ld    = 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_idx != STOP_LAST) begin
                        w_cnt_ld  = 1'b1;
                        w_idx_inc = 1'b1;
                    end else if (r_buf_full || w_req) begin
                        w_state_nxt = S_START;
                        w_cnt_ld    = 1'b1;
                    end else if (DE_TAIL == 0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_TAIL;
                        w_cnt_ld    = 1'b1;
                        w_cnt_val   = TAIL_RELOAD;
                    end
                end
            end
            S_TAIL: begin
                if (w_req) begin
                    w_state_nxt = S_START;
                    w_cnt_ld    = 1'b1;
                end else if (w_bit_end) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Control state: bit timer, bit index, holding-buffer flag, flags and pulse counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fin_d    <= 1'b0;
            r_cnt      <= 16'd0;
            r_idx      <= 3'd0;
            r_buf_full <= 1'b0;
            r_overrun  <= 1'b0;
            r_fin_cnt  <= 4'd0;
        end else begin
            r_fin_d <= bus.data_fin;

            if (w_cnt_ld) begin
                r_cnt <= w_cnt_val;
            end else if (r_cnt != 16'd0) begin
                r_cnt <= r_cnt - 16'd1;
            end

            if (w_idx_clr) begin
                r_idx <= 3'd0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + 3'd1;
            end

            if (w_to_buf) begin
                r_buf_full <= 1'b1;
            end else if (w_unload) begin
                r_buf_full <= 1'b0;
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end

            // The pulse is never stretched or retriggered by a completion while it is active.
            if (w_stop_end && (r_fin_cnt == 4'd0)) begin
                r_fin_cnt <= FIN_LOAD;
            end else if (r_fin_cnt != 4'd0) begin
                r_fin_cnt <= r_fin_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_direct) begin
            r_shift <= bus.data;
        end else if (w_unload) begin
            r_shift <= r_buf;
        end
        if (w_to_buf) begin
            r_buf <= bus.data;
        end
    end

    assign bus.tx           = w_tx;
    assign bus.de           = w_de;
    assign bus.transfer_fin = (r_fin_cnt != 4'd0);
    assign bus.busy         = ((r_state != S_IDLE) && (r_state != S_TAIL)) || r_buf_full;
    assign bus.overrun      = r_overrun;

endmodule

// File: tb/tb_uart_tx_485.sv
// Bench for uart_tx_485: three parameterisations driven by one byte stream, checked every
// cycle against a frame-position model, plus table vectors and directed corner sequences.
`timescale 1ns/1ps
module tb_uart_tx_485;

    localparam int NDUT = 3;
    localparam int D    = 4;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic [7:0] din  = 8'h00;
    logic       dfin = 1'b0;
    int         cyc  = 0;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_485_if u0();
    uart_tx_485_if u1();
    uart_tx_485_if u2();

    assign u0.data = din;  assign u0.data_fin = dfin;
    assign u1.data = din;  assign u1.data_fin = dfin;
    assign u2.data = din;  assign u2.data_fin = dfin;

    uart_tx_485 #(.CLK_DIV(4), .PARITY(0), .STOP_BITS(1), .FIN_W(4), .DE_TAIL(8))
        dut0 (.clk(clk), .rst(rst), .bus(u0));
    uart_tx_485 #(.CLK_DIV(4), .PARITY(2), .STOP_BITS(1), .FIN_W(4), .DE_TAIL(8))
        dut1 (.clk(clk), .rst(rst), .bus(u1));
    uart_tx_485 #(.CLK_DIV(4), .PARITY(1), .STOP_BITS(2), .FIN_W(3), .DE_TAIL(3))
        dut2 (.clk(clk), .rst(rst), .bus(u2));

    function automatic int par_of(int i);
        case (i)
            1:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction
    function automatic int sb_of(int i);   return (i == 2) ? 2 : 1; endfunction
    function automatic int finw_of(int i); return (i == 2) ? 3 : 4; endfunction
    function automatic int tail_of(int i); return (i == 2) ? 3 : 8; endfunction
    function automatic int frame_of(int i);
        return (9 + ((par_of(i) != 0) ? 1 : 0) + sb_of(i)) * D;
    endfunction

    // Outputs packed as {tx, de, transfer_fin, busy, overrun}
    function automatic logic [4:0] act_of(int i);
        case (i)
            0:       return {u0.tx, u0.de, u0.transfer_fin, u0.busy, u0.overrun};
            1:       return {u1.tx, u1.de, u1.transfer_fin, u1.busy, u1.overrun};
            default: return {u2.tx, u2.de, u2.transfer_fin, u2.busy, u2.overrun};
        endcase
    endfunction

    function automatic void chk(string nm, logic [31:0] a, logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, a, e, cyc);
        end
    endfunction

    // Reference model: position inside the current frame, a one-byte queue, tail and pulse timers.
    int         m_pos  [NDUT];
    logic [7:0] m_cur  [NDUT];
    bit         m_qv   [NDUT];
    logic [7:0] m_qb   [NDUT];
    int         m_tail [NDUT];
    int         m_fin  [NDUT];
    bit         m_ovr  [NDUT];
    bit         m_fin_d;

    function automatic void m_reset();
        for (int i = 0; i < NDUT; i++) begin
            m_pos[i] = -1; m_qv[i] = 0; m_tail[i] = 0; m_fin[i] = 0; m_ovr[i] = 0;
            m_cur[i] = 8'h00; m_qb[i] = 8'h00;
        end
        m_fin_d = 0;
    endfunction

    function automatic logic par_bit(int i, logic [7:0] b);
        int ones = $countones(b);
        if (par_of(i) == 1) return ((ones % 2) == 0) ? 1'b1 : 1'b0;
        return ((ones % 2) == 1) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic [4:0] m_expect(int i);
        logic tx = 1'b1, de = 1'b0, busy = m_qv[i];
        int   k;
        if (m_pos[i] >= 0) begin
            de = 1'b1; busy = 1'b1;
            k  = m_pos[i] / D;
            if (k == 0)                          tx = 1'b0;
            else if (k <= 8)                     tx = m_cur[i][k-1];
            else if (par_of(i) != 0 && k == 9)   tx = par_bit(i, m_cur[i]);
        end else if (m_tail[i] > 0) begin
            de = 1'b1;
        end
        return {tx, de, (m_fin[i] > 0), busy, m_ovr[i]};
    endfunction

    function automatic void m_step(int i, bit req, logic [7:0] b);
        int fin_old = m_fin[i];
        bit last    = (m_pos[i] == frame_of(i) - 1);
        if (fin_old > 0) m_fin[i] = fin_old - 1;
        if (last && fin_old == 0) m_fin[i] = finw_of(i);
        if (m_pos[i] >= 0) begin
            if (last) begin
                if (m_qv[i]) begin
                    m_cur[i] = m_qb[i]; m_pos[i] = 0; m_qv[i] = 0;
                    if (req) begin m_qb[i] = b; m_qv[i] = 1; end
                end else if (req) begin
                    m_cur[i] = b; m_pos[i] = 0;
                end else begin
                    m_pos[i] = -1; m_tail[i] = tail_of(i);
                end
            end else begin
                m_pos[i]++;
                if (req) begin
                    if (!m_qv[i]) begin m_qb[i] = b; m_qv[i] = 1; end
                    else m_ovr[i] = 1;
                end
            end
        end else if (req) begin
            m_cur[i] = b; m_pos[i] = 0; m_tail[i] = 0;
        end else if (m_tail[i] > 0) begin
            m_tail[i]--;
        end
    endfunction

    logic [4:0] ck_a, ck_e;
    logic [4:0] prev_act [NDUT];
    int         last_rise [NDUT];
    int         last_defall [NDUT];
    int         rise_cnt0, defall_cnt0;

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NDUT; i++) begin
                ck_a = act_of(i);
                ck_e = rst ? 5'b10000 : m_expect(i);
                chk($sformatf("model_d%0d", i), ck_a, ck_e);
                if (ck_a[2] && !prev_act[i][2]) begin
                    last_rise[i] = cyc;
                    if (i == 0) rise_cnt0++;
                end
                if (!ck_a[3] && prev_act[i][3]) begin
                    last_defall[i] = cyc;
                    if (i == 0) defall_cnt0++;
                end
                prev_act[i] = ck_a;
            end
            if (rst) m_reset();
            else begin
                for (int i = 0; i < NDUT; i++) m_step(i, dfin && !m_fin_d, din);
                m_fin_d = dfin;
            end
        end
    end

    typedef struct {
        logic [7:0] b;
        logic       par_e;
        logic       par_o;
    } vec_t;

    function automatic logic exp_bit(int i, int k, vec_t r);
        if (k == 0) return 1'b0;
        if (k <= 8) return r.b[k-1];
        if (k == 9 && par_of(i) == 2) return r.par_e;
        if (k == 9 && par_of(i) == 1) return r.par_o;
        return 1'b1;
    endfunction

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic wait_until(int c); while (cyc < c) tick(); endtask
    task automatic req(logic [7:0] b); din = b; dfin = 1'b1; tick(); dfin = 1'b0; endtask
    task automatic do_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
        rise_cnt0 = 0; defall_cnt0 = 0;
    endtask

    vec_t       tbl [6];
    int         n;
    logic [4:0] a;
    int         r;

    initial begin
        m_reset();
        for (int i = 0; i < NDUT; i++) begin
            prev_act[i] = 5'b10000; last_rise[i] = -1; last_defall[i] = -1;
        end
        rise_cnt0 = 0; defall_cnt0 = 0;
        tbl[0] = '{8'hAA, 1'b0, 1'b1};
        tbl[1] = '{8'h16, 1'b1, 1'b0};
        tbl[2] = '{8'hFF, 1'b0, 1'b1};
        tbl[3] = '{8'h02, 1'b1, 1'b0};
        tbl[4] = '{8'h00, 1'b0, 1'b1};
        tbl[5] = '{8'h80, 1'b1, 1'b0};

        repeat (3) tick();
        chk("reset_outputs", act_of(0), 5'b10000);
        rst = 1'b0;
        repeat (2) tick();
        chk("idle_after_reset", act_of(1), 5'b10000);

        for (int v = 0; v < 6; v++) begin
            n = cyc;
            req(tbl[v].b);
            tick(); tick();
            for (int k = 0; k < 12; k++) begin
                for (int i = 0; i < NDUT; i++) begin
                    a = act_of(i);
                    chk($sformatf("frame_v%0d_d%0d_bit%0d", v, i, k), a[4], exp_bit(i, k, tbl[v]));
                end
                repeat (4) tick();
            end
            wait_until(n + 60);
            for (int i = 0; i < NDUT; i++) begin
                chk($sformatf("fin_rise_v%0d_d%0d", v, i), last_rise[i], n + frame_of(i) + 1);
                chk($sformatf("de_fall_v%0d_d%0d", v, i), last_defall[i],
                    n + frame_of(i) + tail_of(i) + 1);
            end
        end

        // Second byte offered mid-frame follows the first with no idle gap.
        do_reset();
        n = cyc; req(8'hAA);
        wait_until(n + 9); req(8'h02);
        wait_until(n + 41);
        a = act_of(0);
        chk("b2b_start_bit", a[4], 1'b0);
        chk("b2b_de_held", a[3], 1'b1);
        wait_until(n + 100);
        chk("b2b_fin_count", rise_cnt0, 2);
        chk("b2b_fin2_cycle", last_rise[0], n + 81);
        chk("b2b_de_falls", defall_cnt0, 1);
        chk("b2b_de_fall_cycle", last_defall[0], n + 89);
        a = act_of(0);
        chk("b2b_no_overrun", a[0], 1'b0);

        // Third byte in one frame is dropped and overrun sticks until reset.
        do_reset();
        n = cyc; req(8'h11);
        wait_until(n + 4); req(8'h22);
        wait_until(n + 8); req(8'h33);
        a = act_of(0);
        chk("ovr_set", a[0], 1'b1);
        wait_until(n + 120);
        a = act_of(0);
        chk("ovr_sticky", a[0], 1'b1);
        chk("ovr_two_frames", rise_cnt0, 2);
        do_reset();
        a = act_of(0);
        chk("ovr_cleared_by_reset", a[0], 1'b0);

        // A level held high is a single request.
        do_reset();
        n = cyc; din = 8'h5A; dfin = 1'b1;
        repeat (100) tick();
        dfin = 1'b0;
        wait_until(n + 170);
        chk("held_level_one_frame", rise_cnt0, 1);

        // Buffer unload and a new request in the same cycle: no drop.
        do_reset();
        n = cyc; req(8'h01);
        wait_until(n + 5); req(8'h02);
        wait_until(n + 40); req(8'h03);
        wait_until(n + 140);
        chk("unload_req_fin_count", rise_cnt0, 3);
        chk("unload_req_fin3_cycle", last_rise[0], n + 121);
        a = act_of(0);
        chk("unload_req_no_overrun", a[0], 1'b0);

        // Request in the final stop cycle with the buffer empty.
        do_reset();
        n = cyc; req(8'h0F);
        wait_until(n + 40); req(8'hF0);
        a = act_of(0);
        chk("last_stop_req_start", a[4], 1'b0);
        chk("last_stop_req_busy", a[1], 1'b1);
        wait_until(n + 100);
        chk("last_stop_req_fins", rise_cnt0, 2);
        chk("last_stop_req_fin2", last_rise[0], n + 81);

        // Reset during data bit 3 aborts at once; the next frame is clean.
        do_reset();
        n = cyc; req(8'h00);
        wait_until(n + 17);
        a = act_of(0);
        chk("abort_bit3_low", a[4], 1'b0);
        rst = 1'b1;
        #1;
        chk("abort_outputs", act_of(0), 5'b10000);
        tick(); rst = 1'b0; tick();
        rise_cnt0 = 0;
        n = cyc; req(8'hC3);
        wait_until(n + 60);
        chk("post_abort_fin", last_rise[0], n + 41);
        chk("post_abort_fin_count", rise_cnt0, 1);

        // Random traffic, occasional resets; the per-cycle model does the checking.
        do_reset();
        repeat (3000) begin
            r = $urandom_range(0, 99);
            if (r < 4)       dfin = 1'b1;
            else if (r < 50) dfin = 1'b0;
            din = 8'($urandom);
            rst = ($urandom_range(0, 1499) == 0);
            tick();
        end
        rst = 1'b0; dfin = 1'b0;
        repeat (120) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
